// File: rtl/traffic_pkg.sv
// Shared types for the two-road phase controller: lamp encodings, phase codes, dwell counter width.
package traffic_pkg;

    localparam int CNT_W = 8;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b001;

    typedef enum logic [2:0] {
        MAIN_GO   = 3'd0,
        MAIN_WARN = 3'd1,
        ALLRED_A  = 3'd2,
        SIDE_GO   = 3'd3,
        SIDE_WARN = 3'd4,
        ALLRED_B  = 3'd5
    } phase_e;

    // Returns {main_head, side_head}; anything unrecognised shows red on both.
    function automatic logic [5:0] lamps(input phase_e s);
        case (s)
            MAIN_GO:   lamps = {GREEN,  RED};
            MAIN_WARN: lamps = {YELLOW, RED};
            SIDE_GO:   lamps = {RED,    GREEN};
            SIDE_WARN: lamps = {RED,    YELLOW};
            default:   lamps = {RED,    RED};
        endcase
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Cycles-in-phase counter: zero on clear, otherwise counts up and sticks at all-ones.
module dwell_timer
    import traffic_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Main/side intersection phase sequencer with registered lamp and phase outputs.
// Optional pedestrian request/walk indication when PED_WALK_EN is defined.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 32,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [2:0] phase,
    output logic       side_ack
`ifdef PED_WALK_EN
    ,
    input  logic       ped_req,
    output logic       walk
`endif
);

    localparam logic [CNT_W-1:0] GMIN_M1   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_T - 1);

    phase_e           state;
    phase_e           state_nxt;
    logic [CNT_W-1:0] count;
    logic             clr;
    logic             enter_side;
    logic             req_set;
    logic             pending;

`ifdef PED_WALK_EN
    assign req_set = side_req | ped_req;
`else
    assign req_set = side_req;
`endif

    dwell_timer u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .count (count)
    );

    always_comb begin
        state_nxt = MAIN_GO;
        case (state)
            MAIN_GO:   state_nxt = (count >= GMIN_M1 && (pending || side_req)) ? MAIN_WARN : MAIN_GO;
            MAIN_WARN: state_nxt = (count == YELLOW_M1) ? ALLRED_A : MAIN_WARN;
            ALLRED_A:  state_nxt = (count == ALLRED_M1) ? SIDE_GO : ALLRED_A;
            SIDE_GO:   state_nxt = (count >= GMIN_M1 && (!side_req || count == GMAX_M1)) ? SIDE_WARN : SIDE_GO;
            SIDE_WARN: state_nxt = (count == YELLOW_M1) ? ALLRED_B : SIDE_WARN;
            ALLRED_B:  state_nxt = (count == ALLRED_M1) ? MAIN_GO : ALLRED_B;
            default:   state_nxt = MAIN_GO;
        endcase
        clr        = (state_nxt != state);
        enter_side = (state_nxt == SIDE_GO) && (state != SIDE_GO);
    end

    // Lamps are decoded from the next state so they change on the same edge as the phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= MAIN_GO;
            main_light <= GREEN;
            side_light <= RED;
            pending    <= 1'b0;
            side_ack   <= 1'b0;
        end else begin
            state                    <= state_nxt;
            {main_light, side_light} <= lamps(state_nxt);
            side_ack                 <= enter_side;
            if (enter_side) begin
                pending <= 1'b0;
            end else if (req_set && (state == MAIN_GO || state == MAIN_WARN || state == ALLRED_A)) begin
                pending <= 1'b1;
            end
        end
    end

    assign phase = state;

`ifdef PED_WALK_EN
    // Next count is 0 on entry, else count+1; count+1 < GREEN_MIN <=> count < GREEN_MIN-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            walk <= 1'b0;
        end else begin
            walk <= (state_nxt == SIDE_GO) && (clr || count < GMIN_M1);
        end
    end
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomised and directed bench for traffic_phase_ctrl against a phase/dwell reference model.
module tb_traffic_phase_ctrl;

    localparam int GMIN = 8;
    localparam int GMAX = 32;
    localparam int YT   = 3;
    localparam int AT   = 1;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       side_req = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [2:0] phase;
    logic       side_ack;
`ifdef PED_WALK_EN
    logic       ped_req = 1'b0;
    logic       walk;
`endif

    always #5 clk = ~clk;

    traffic_phase_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .side_req   (side_req),
        .main_light (main_light),
        .side_light (side_light),
        .phase      (phase),
        .side_ack   (side_ack)
`ifdef PED_WALK_EN
        ,
        .ped_req    (ped_req),
        .walk       (walk)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference: phase index 0..5, cycles spent in it, latched request.
    int         m_ph = 0;
    int         m_cnt = 0;
    bit         m_pend = 0;
    bit         m_ack = 0;
    bit         m_walk = 0;
    int         cyc = 0;
    logic [2:0] main_tbl [6] = '{G, Y, R, R, R, R};
    logic [2:0] side_tbl [6] = '{R, R, R, G, Y, R};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit p);
        int nxt;
        if (!r) begin
            m_ph = 0; m_cnt = 0; m_pend = 0; m_ack = 0; m_walk = 0;
        end else begin
            nxt = m_ph;
            case (m_ph)
                0:       if (m_cnt >= GMIN - 1 && (m_pend || s)) nxt = 1;
                1, 4:    if (m_cnt == YT - 1) nxt = m_ph + 1;
                2, 5:    if (m_cnt == AT - 1) nxt = (m_ph + 1) % 6;
                default: if (m_cnt >= GMIN - 1 && (!s || m_cnt == GMAX - 1)) nxt = 4;
            endcase
            m_ack = (nxt == 3 && m_ph != 3);
            if (m_ack) m_pend = 0;
            else if ((s || p) && m_ph <= 2) m_pend = 1;
            m_cnt = (nxt != m_ph) ? 0 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            m_ph = nxt;
            m_walk = (m_ph == 3 && m_cnt < GMIN);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit p);
        @(negedge clk);
        rst_n = r;
        side_req = s;
`ifdef PED_WALK_EN
        ped_req = p;
`endif
        @(posedge clk);
        model_step(r, s, p);
        cyc = r ? cyc + 1 : 0;
        #1;
        check_val("main", main_light, main_tbl[m_ph]);
        check_val("side", side_light, side_tbl[m_ph]);
        check_val("phase", phase, m_ph);
        check_val("ack", side_ack, m_ack);
        check_val("conflict", (main_light != R) && (side_light != R), 0);
`ifdef PED_WALK_EN
        check_val("walk", walk, m_walk);
`endif
    endtask

    initial begin
        int len;
        int n;
        int mlen;
        int mode;
        bit s;
        bit p;

        // Reset values and long idle hold
        step(0, 0, 0);
        check_val("rst_main", main_light, G);
        check_val("rst_side", side_light, R);
        check_val("rst_phase", phase, 0);
        check_val("rst_ack", side_ack, 0);
        repeat (200) step(1, 0, 0);
        check_val("idle_phase", phase, 0);
        check_val("idle_main", main_light, G);

        // Single request pulse sampled at the end of cycle 2
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        while (cyc < 13) begin
            step(1, 0, 0);
            case (cyc)
                7:  check_val("pulse_c7_main", main_light, G);
                8:  check_val("pulse_c8_main", main_light, Y);
                10: check_val("pulse_c10_main", main_light, Y);
                11: check_val("pulse_c11_red", {main_light, side_light}, {R, R});
                12: begin
                    check_val("pulse_c12_side", side_light, G);
                    check_val("pulse_c12_ack", side_ack, 1);
                end
                default: ;
            endcase
        end

        // Request held: every side green run is GREEN_MAX, every main green run GREEN_MIN
        step(0, 1, 0);
        len = 0;
        mlen = (main_light == G) ? 1 : 0;
        repeat (150) begin
            step(1, 1, 0);
            if (side_light == G) len++;
            else if (len > 0) begin
                check_val("held_side_green", len, GMAX);
                len = 0;
            end
            if (main_light == G) mlen++;
            else if (mlen > 0) begin
                check_val("held_main_green", mlen, GMIN);
                mlen = 0;
            end
        end

        // Request drops four cycles into side green
        step(0, 0, 0);
        n = 0;
        while (m_ph != 3 && n < 100) begin
            step(1, 1, 0);
            n++;
        end
        check_val("drop_reach_side", side_light, G);
        len = 1;
        n = 0;
        while (side_light == G && n < 100) begin
            step(1, m_cnt < 3, 0);
            if (side_light == G) len++;
            n++;
        end
        check_val("drop_side_len", len, GMIN);
        check_val("drop_then_yellow", side_light, Y);

        // Reset in the middle of side green
        step(0, 0, 0);
        n = 0;
        while (!(m_ph == 3 && m_cnt == 5) && n < 100) begin
            step(1, 1, 0);
            n++;
        end
        check_val("midrst_reach", side_light, G);
        step(0, 1, 0);
        check_val("midrst_main", main_light, G);
        check_val("midrst_side", side_light, R);
        check_val("midrst_phase", phase, 0);
        repeat (30) begin
            step(1, 0, 0);
            check_val("midrst_hold", main_light, G);
        end

`ifdef PED_WALK_EN
        // Pedestrian-only request
        step(0, 0, 0);
        step(1, 0, 1);
        n = 0;
        while (side_light != G && n < 100) begin
            step(1, 0, 0);
            n++;
        end
        len = 0;
        n = 0;
        while (side_light == G && n < 100) begin
            if (walk) len++;
            step(1, 0, 0);
            n++;
        end
        check_val("ped_walk_len", len, GMIN);
        check_val("ped_then_yellow", side_light, Y);
`endif

        // Randomised traffic with occasional resets
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) mode = $urandom_range(0, 2);
            case (mode)
                0:       s = ($urandom_range(0, 15) == 0);
                1:       s = ($urandom_range(0, 15) != 0);
                default: s = $urandom_range(0, 1);
            endcase
`ifdef PED_WALK_EN
            p = ($urandom_range(0, 31) == 0);
`else
            p = 1'b0;
`endif
            step($urandom_range(0, 399) != 0, s, p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
